// File: rtl/myniosiicpu_led_out.sv
// myniosiicpu_led_out: memory-mapped LED/GPIO output port.
// Register map:
//   0 data      RW
//   1 pulse_len RW (16 bits)
//   2 pulse     write starts pulses, read returns pulse_active
//   4 outset    write-only, ORs bits into data
//   5 outclear  write-only, clears bits in data
//   3, 6, 7     read 0, writes ignored
// Optional feature macro: MYNIOSIICPU_LED_OUT_PULSE_EN compiles in the timed-pulse
// logic (per-bit 16-bit down-counters and registers 1 and 2).
// Without it, registers 1 and 2 read 0 and out_port = data.
//
// Bus handshake: there is no valid/ready pair. A write is accepted unconditionally
// at a rising clk edge where chipselect=1 and write_n=0. readdata is registered
// from the address mux every cycle, so it is valid one clock after address is
// presented, whatever chipselect is doing.
module myniosiicpu_led_out #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] pulse_active;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wdata_w   = writedata[WIDTH-1:0];
  // Bits of writedata above WIDTH (and above 16 for pulse_len) are ignored.
  assign unused_wd = ^writedata;

  // Next value of the data register: load, set or clear.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_d = wdata_w;
        3'd4:    data_d = data_q | wdata_w;
        3'd5:    data_d = data_q & ~wdata_w;
        default: data_d = data_q;
      endcase
    end
  end

`ifdef MYNIOSIICPU_LED_OUT_PULSE_EN
  logic [15:0]      pulse_len_q, pulse_len_d;
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] start_w;

  // A start with pulse_len = 0 does nothing at all.
  assign start_w = (wr_en && (address == 3'd2) && (pulse_len_q != 16'd0)) ? wdata_w : '0;

  // Pulse length register; running pulses keep the length they were started with.
  always_comb begin
    pulse_len_d = pulse_len_q;
    if (wr_en && (address == 3'd1)) pulse_len_d = writedata[15:0];
  end

  // Per-bit counters: a start (or retrigger) reloads to pulse_len, otherwise count
  // down and drop the active flag on the 1 -> 0 step so the bit inverts N clocks.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]    = cnt_q[i];
      active_d[i] = active_q[i];
      if (start_w[i]) begin
        cnt_d[i]    = pulse_len_q;
        active_d[i] = 1'b1;
      end else if (cnt_q[i] != 16'd0) begin
        cnt_d[i] = cnt_q[i] - 16'd1;
        if (cnt_q[i] == 16'd1) active_d[i] = 1'b0;
      end
    end
  end

  // Pulse state registers; reset abandons any pulse in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pulse_len_q <= '0;
      active_q    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      pulse_len_q <= pulse_len_d;
      active_q    <= active_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pulse_active = active_q;
`else
  assign pulse_active = '0;
`endif

  // Read mux, registered below regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d[WIDTH-1:0] = data_q;
`ifdef MYNIOSIICPU_LED_OUT_PULSE_EN
      3'd1: readdata_d[15:0]      = pulse_len_q;
      3'd2: readdata_d[WIDTH-1:0] = active_q;
`endif
      default: readdata_d = '0;
    endcase
  end

  // Data and read-data registers; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ pulse_active;

endmodule

// File: tb/tb_myniosiicpu_led_out.sv
// Directed bench for myniosiicpu_led_out (WIDTH=8, RESET_VALUE=0x5A).
// Pulse checks are compiled when MYNIOSIICPU_LED_OUT_PULSE_EN is defined,
// otherwise the disabled-feature behaviour is checked instead.
module tb_myniosiicpu_led_out;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk;
  logic         reset_n;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  logic [31:0]  exp_q[$];
  int           n_tests;
  int           n_fail;

  myniosiicpu_led_out #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Bus write: called at a negedge, returns at the following negedge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // One clock: check out_port now, present a read address, expect its data next.
  task automatic tick(input string tag, input logic [W-1:0] exp_out,
                      input logic [2:0] a, input logic [31:0] exp_rd);
    logic [31:0] e;
    chk({tag, "_out"}, {24'd0, out_port}, {24'd0, exp_out});
    address = a;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_rd scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rd"}, readdata, e);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'hFF;

    // Reset, with a write held active that must be ignored
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {24'd0, out_port}, {24'd0, RV});
    chk("rst_rd", readdata, 32'd0);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick("rst_data", RV, 3'd0, {24'd0, RV});

    // Data load and readback
    bus_wr(3'd0, 32'h0000_00A5);
    tick("wr_a5", 8'hA5, 3'd0, 32'hA5);

    // outset / outclear
    bus_wr(3'd4, 32'h0F);
    tick("outset", 8'hAF, 3'd4, 32'd0);
    bus_wr(3'd5, 32'h81);
    tick("outclr", 8'h2E, 3'd5, 32'd0);

    // Unused addresses
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd6, 32'hFF);
    bus_wr(3'd7, 32'hFF);
    tick("addr3", 8'h2E, 3'd3, 32'd0);
    tick("addr6", 8'h2E, 3'd6, 32'd0);
    tick("addr7", 8'h2E, 3'd7, 32'd0);

    // Bits above WIDTH ignored
    bus_wr(3'd0, 32'hFFFF_FF00);
    tick("wide_wr", 8'h00, 3'd0, 32'd0);

`ifdef MYNIOSIICPU_LED_OUT_PULSE_EN
    // pulse_len keeps 16 bits only
    bus_wr(3'd1, 32'hABCD_0003);
    tick("plen3", 8'h00, 3'd1, 32'd3);

    // 3-clock pulse on bit 0
    bus_wr(3'd2, 32'h01);
    tick("p3_c1", 8'h01, 3'd2, 32'h01);
    tick("p3_c2", 8'h01, 3'd2, 32'h01);
    tick("p3_c3", 8'h01, 3'd2, 32'h01);
    tick("p3_end", 8'h00, 3'd2, 32'h00);

    // Retrigger on bit 1 after 2 clocks; pulse_len and data written mid-pulse
    bus_wr(3'd1, 32'd4);
    bus_wr(3'd2, 32'h02);
    tick("p4_c1", 8'h02, 3'd2, 32'h02);
    bus_wr(3'd2, 32'h02);
    bus_wr(3'd1, 32'd10);
    bus_wr(3'd0, 32'h80);
    tick("p4_c5", 8'h82, 3'd2, 32'h02);
    tick("p4_c6", 8'h82, 3'd2, 32'h02);
    tick("p4_end", 8'h80, 3'd2, 32'h00);
    tick("plen10", 8'h80, 3'd1, 32'd10);

    // pulse_len = 0 start does nothing
    bus_wr(3'd1, 32'd0);
    bus_wr(3'd2, 32'hFF);
    tick("plen0", 8'h80, 3'd2, 32'd0);

    // Long pulse cut short by reset
    bus_wr(3'd1, 32'd100);
    bus_wr(3'd2, 32'h01);
    tick("p100", 8'h81, 3'd2, 32'h01);
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h33;
    @(negedge clk);
    chk("rst2_out", {24'd0, out_port}, {24'd0, RV});
    chk("rst2_rd", readdata, 32'd0);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick("rst2_p1", RV, 3'd2, 32'd0);
    tick("rst2_p2", RV, 3'd2, 32'd0);
    tick("rst2_len", RV, 3'd1, 32'd0);
`else
    // Pulse registers absent: read 0, writes ignored, out_port = data
    bus_wr(3'd1, 32'd5);
    tick("nop_len", 8'h00, 3'd1, 32'd0);
    bus_wr(3'd2, 32'hFF);
    tick("nop_pulse", 8'h00, 3'd2, 32'd0);
    bus_wr(3'd0, 32'h3C);
    tick("nop_data", 8'h3C, 3'd2, 32'd0);
    tick("nop_rd0", 8'h3C, 3'd0, 32'h3C);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_out", {24'd0, out_port}, {24'd0, RV});
    chk("rst2_rd", readdata, 32'd0);
    reset_n = 1'b1;
    tick("rst2_data", RV, 3'd0, {24'd0, RV});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
